// File: rtl/mips_pkg.sv
// Shared MIPS fetch/decode constants: branch and jump class codes,
// the reset PC and the canonical nop word.
package mips_pkg;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BGEZ = 3'd3;
  localparam logic [2:0] BR_BGTZ = 3'd4;
  localparam logic [2:0] BR_BLTZ = 3'd5;
  localparam logic [2:0] BR_BLEZ = 3'd6;

  localparam logic [1:0] J_NONE = 2'd0;
  localparam logic [1:0] J_IMM  = 2'd1;
  localparam logic [1:0] J_REG  = 2'd2;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_npc_unit_npc_calc.sv
// Combinational next-PC logic: branch decision, redirect target and
// the redirect strobe for the instruction sitting in D.
module npc_calc
  import mips_pkg::*;
(
  input  logic        stall,
  input  logic [31:0] pc_d,
  input  logic [25:0] imm26_d,
  input  logic [2:0]  br_op_d,
  input  logic [1:0]  j_op_d,
  input  logic        equal_in,
  input  logic        bgez_in,
  input  logic        bgtz_in,
  input  logic        bltz_in,
  input  logic        blez_in,
  input  logic [31:0] rs_val_d,
  output logic        taken_o,
  output logic [31:0] target_o,
  output logic        redirect_o
);

  logic j_imm;
  logic j_reg;
  logic [31:0] br_tgt;

  assign j_imm  = (j_op_d == J_IMM);
  assign j_reg  = (j_op_d == J_REG);
  assign br_tgt = pc_d + 32'd4 + br_offset(imm26_d[15:0]);

  always_comb begin
    taken_o = 1'b0;
    unique case (br_op_d)
      BR_BEQ:  taken_o = equal_in;
      BR_BNE:  taken_o = !equal_in;
      BR_BGEZ: taken_o = bgez_in;
      BR_BGTZ: taken_o = bgtz_in;
      BR_BLTZ: taken_o = bltz_in;
      BR_BLEZ: taken_o = blez_in;
      default: taken_o = 1'b0;
    endcase
  end

  // Jumps outrank branches when decode sets both.
  always_comb begin
    target_o = br_tgt;
    unique case (1'b1)
      j_imm:   target_o = {pc_d[31:28], imm26_d, 2'b00};
      j_reg:   target_o = rs_val_d;
      default: target_o = br_tgt;
    endcase
  end

  assign redirect_o = !stall && (taken_o || j_imm || j_reg);

endmodule

// File: rtl/fetch_npc_unit.sv
// Fetch PC register, next-PC mux and IF/ID register.
// Optional annulled delay slot for likely branches: BRANCH_LIKELY_EN.
module fetch_npc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instr_f,
  input  logic [2:0]  br_op_d,
  input  logic [1:0]  j_op_d,
  input  logic        equal_in,
  input  logic        bgez_in,
  input  logic        bgtz_in,
  input  logic        bltz_in,
  input  logic        blez_in,
  input  logic [31:0] rs_val_d,
`ifdef BRANCH_LIKELY_EN
  input  logic        likely_d,
`endif
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        redirect_d,
  output logic        fetch_err
);

  localparam logic [31:0] IM_BYTES = 32'(IM_WORDS * 4);

  logic [31:0] pc_q, pc_nd;
  logic [31:0] ir_q;
  logic [31:0] pcd_q;
  logic        err_q, err_d;
  logic        taken;
  logic [31:0] target;
  logic [31:0] im_off;

  npc_calc u_npc (
    .stall     (stall),
    .pc_d      (pcd_q),
    .imm26_d   (instr_d[25:0]),
    .br_op_d   (br_op_d),
    .j_op_d    (j_op_d),
    .equal_in  (equal_in),
    .bgez_in   (bgez_in),
    .bgtz_in   (bgtz_in),
    .bltz_in   (bltz_in),
    .blez_in   (blez_in),
    .rs_val_d  (rs_val_d),
    .taken_o   (taken),
    .target_o  (target),
    .redirect_o(redirect_d)
  );

  assign pc_nd  = redirect_d ? target : pc_q + 32'd4;
  assign im_off = pc_q - IM_BASE;
  assign err_d  = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE)
               || (im_off >= IM_BYTES);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      ir_q  <= NOP;
      pcd_q <= RESET_PC;
      err_q <= 1'b0;
    end else if (!stall) begin
      pc_q  <= pc_nd;
      ir_q  <= instr_f;
      pcd_q <= pc_q;
      err_q <= err_d;
    end
  end

`ifdef BRANCH_LIKELY_EN
  logic annul, annul_q;

  assign annul = likely_d && (br_op_d != BR_NONE) && !taken && !stall;

  // Squash flag masks the slot captured alongside it until D advances.
  always_ff @(posedge clk) begin
    if (reset)
      annul_q <= 1'b0;
    else if (!stall)
      annul_q <= annul;
  end

  assign instr_d   = annul_q ? NOP : ir_q;
  assign fetch_err = err_q && !annul_q;
`else
  assign instr_d   = ir_q;
  assign fetch_err = err_q;
  logic unused_taken;
  assign unused_taken = taken;
`endif

  assign pc_f  = pc_q;
  assign pc_d  = pcd_q;
  assign pc8_d = pcd_q + 32'd8;

endmodule

// File: tb/tb_fetch_npc_unit.sv
// Directed self-checking bench for fetch_npc_unit.
module tb_fetch_npc_unit;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic [31:0] instr_f, rs_val_d;
  logic [2:0]  br_op_d;
  logic [1:0]  j_op_d;
  logic        equal_in, bgez_in, bgtz_in, bltz_in, blez_in;
`ifdef BRANCH_LIKELY_EN
  logic        likely_d;
`endif
  logic [31:0] pc_f, instr_d, pc_d, pc8_d;
  logic        redirect_d, fetch_err;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  fetch_npc_unit dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .instr_f   (instr_f),
    .br_op_d   (br_op_d),
    .j_op_d    (j_op_d),
    .equal_in  (equal_in),
    .bgez_in   (bgez_in),
    .bgtz_in   (bgtz_in),
    .bltz_in   (bltz_in),
    .blez_in   (blez_in),
    .rs_val_d  (rs_val_d),
`ifdef BRANCH_LIKELY_EN
    .likely_d  (likely_d),
`endif
    .pc_f      (pc_f),
    .instr_d   (instr_d),
    .pc_d      (pc_d),
    .pc8_d     (pc8_d),
    .redirect_d(redirect_d),
    .fetch_err (fetch_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic [31:0] e_pcf,
                        input logic [31:0] e_ir, input logic [31:0] e_pcd,
                        input logic e_err);
    chk({tag, ".pc_f"}, pc_f, e_pcf);
    chk({tag, ".instr_d"}, instr_d, e_ir);
    chk({tag, ".pc_d"}, pc_d, e_pcd);
    chk({tag, ".fetch_err"}, {31'd0, fetch_err}, {31'd0, e_err});
  endtask

  initial begin
    reset = 1; stall = 0; instr_f = 32'h0; rs_val_d = 32'h0;
    br_op_d = 0; j_op_d = 0;
    equal_in = 0; bgez_in = 0; bgtz_in = 0; bltz_in = 0; blez_in = 0;
`ifdef BRANCH_LIKELY_EN
    likely_d = 0;
`endif
    tick(); tick();
    chk_st("reset", 32'h3000, 32'h0, 32'h3000, 1'b0);

    reset = 0;
    tick();
    chk_st("seq1", 32'h3004, 32'h0, 32'h3000, 1'b0);
    instr_f = 32'h1000_0003;
    tick();
    chk_st("seq2", 32'h3008, 32'h1000_0003, 32'h3004, 1'b0);

    // beq +3 from 0x3004 -> 0x3014; delay slot still lands in D
    br_op_d = 1; equal_in = 1; instr_f = 32'hAAAA_0001;
    #1 chk("beq.redirect", {31'd0, redirect_d}, 32'd1);
    tick();
    chk_st("beq", 32'h3014, 32'hAAAA_0001, 32'h3008, 1'b0);

    br_op_d = 0; equal_in = 0; instr_f = 32'h0000_FFFC;
    tick();
    chk("pre_bltz.pc_f", pc_f, 32'h3018);
    // bltz -4 at 0x3014 -> 0x3008
    br_op_d = 5; bltz_in = 1; instr_f = 32'hBBBB_0000;
    tick();
    chk_st("bltz_t", 32'h3008, 32'hBBBB_0000, 32'h3018, 1'b0);

    br_op_d = 0; bltz_in = 0; instr_f = 32'h0000_FFFC;
    tick();
    chk("pre_bltz_nt.pc_f", pc_f, 32'h300C);
    br_op_d = 5; bltz_in = 0;
    #1 chk("bltz_nt.redirect", {31'd0, redirect_d}, 32'd0);
    tick();
    chk("bltz_nt.pc_f", pc_f, 32'h3010);

    // beq +2 at 0x3010 held in D across a 3-cycle stall
    br_op_d = 0; instr_f = 32'h1000_0002;
    tick();
    chk_st("pre_stall", 32'h3014, 32'h1000_0002, 32'h3010, 1'b0);
    br_op_d = 1; stall = 1; instr_f = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      equal_in = (i % 2 == 0);
      #1 chk("stall.redirect", {31'd0, redirect_d}, 32'd0);
      tick();
      chk_st("stall", 32'h3014, 32'h1000_0002, 32'h3010, 1'b0);
    end
    stall = 0; equal_in = 1; instr_f = 32'hCCCC_0000;
    #1 chk("unstall.redirect", {31'd0, redirect_d}, 32'd1);
    tick();
    chk_st("unstall", 32'h301C, 32'hCCCC_0000, 32'h3014, 1'b0);

    // jal 0xC10 with a conflicting taken beq: jump wins
    br_op_d = 0; equal_in = 0; instr_f = 32'h0C00_0C10;
    tick();
    chk("jal.pc8_d", pc8_d, 32'h3024);
    j_op_d = 1; br_op_d = 1; equal_in = 1; instr_f = 32'h0;
    tick();
    chk_st("jal", 32'h3040, 32'h0, 32'h3020, 1'b0);

    // jr to misaligned target, error reported once it reaches D
    j_op_d = 2; br_op_d = 0; equal_in = 0; rs_val_d = 32'h3002;
    tick();
    chk_st("jr", 32'h3002, 32'h0, 32'h3040, 1'b0);
    j_op_d = 0;
    tick();
    chk_st("jr_err", 32'h3006, 32'h0, 32'h3002, 1'b1);

    // IM bounds: last word ok, one past end and below base flagged
    j_op_d = 2; rs_val_d = 32'h6FFC;
    tick();
    rs_val_d = 32'h7000;
    tick();
    chk_st("im_last", 32'h7000, 32'h0, 32'h6FFC, 1'b0);
    rs_val_d = 32'h2FFC;
    tick();
    chk_st("im_end", 32'h2FFC, 32'h0, 32'h7000, 1'b1);
    j_op_d = 0;
    tick();
    chk_st("im_below", 32'h3000, 32'h0, 32'h2FFC, 1'b1);

    // PC wrap
    j_op_d = 2; rs_val_d = 32'hFFFF_FFFC;
    tick();
    j_op_d = 0;
    tick();
    chk("wrap.pc_f", pc_f, 32'h0);

    // reset while stalled with a taken branch in D
    stall = 1; br_op_d = 1; equal_in = 1; instr_f = 32'h1234_5678;
    reset = 1;
    tick();
    chk_st("rst_stall", 32'h3000, 32'h0, 32'h3000, 1'b0);
    reset = 0; stall = 0; br_op_d = 0; equal_in = 0;

`ifdef BRANCH_LIKELY_EN
    instr_f = 32'h1400_0005;
    tick();
    chk("bnel.pre", pc_f, 32'h3004);
    br_op_d = 2; likely_d = 1; equal_in = 1; instr_f = 32'hDDDD_0000;
    tick();
    chk_st("bnel_nt", 32'h3008, 32'h0, 32'h3004, 1'b0);
    br_op_d = 0; likely_d = 0; equal_in = 0; instr_f = 32'h1400_0005;
    tick();
    chk_st("bnel.pre2", 32'h300C, 32'h1400_0005, 32'h3008, 1'b0);
    br_op_d = 2; likely_d = 1; equal_in = 0; instr_f = 32'hEEEE_0000;
    tick();
    chk_st("bnel_t", 32'h3020, 32'hEEEE_0000, 32'h300C, 1'b0);
    br_op_d = 0; likely_d = 0;
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/fetch_npc_unit.md
Name: fetch_npc_unit

Overview:
- Owns the fetch-stage PC register, the next-PC selection and the IF/ID pipeline register of the 5-stage MIPS pipeline.
- Sits directly downstream of the decode-stage branch comparator. It consumes that comparator's `equal`/`bgez`/`bgtz`/`bltz`/`blez` flags, together with the branch/jump class decoded in D, and redirects fetch.
- Architectural delay slot: the instruction fetched while a branch is in D is always passed to D, unless the optional annul feature squashes it.

Parameters:
- `RESET_PC`, `32'h0000_3000`, PC value loaded on reset.
- `IM_BASE`, `32'h0000_3000`, lowest legal fetch address, used by the `fetch_err` check.
- `IM_WORDS`, `4096`, instruction memory depth in words, used by the `fetch_err` check.

Ports:
- `clk` input 1: single clock.
- `reset` input 1: synchronous, active-high reset.
- `stall` input 1: hazard-unit stall; freezes PC and IF/ID.
- `instr_f` input 32: instruction read from IM at `pc_f`.
- `br_op_d` input 3: D-stage branch class. 0 none, 1 beq, 2 bne, 3 bgez, 4 bgtz, 5 bltz, 6 blez, 7 reserved (treated as none).
- `j_op_d` input 2: D-stage jump class. 0 none, 1 j/jal (imm26), 2 jr/jalr (register), 3 reserved (treated as none).
- `equal_in` input 1: comparator flag.
- `bgez_in` input 1: comparator flag.
- `bgtz_in` input 1: comparator flag.
- `bltz_in` input 1: comparator flag.
- `blez_in` input 1: comparator flag.
- `rs_val_d` input 32: forwarded rs value, used as the jr target.
- `pc_f` output 32: current fetch PC, drives the IM address.
- `instr_d` output 32: IF/ID instruction.
- `pc_d` output 32: IF/ID PC.
- `pc8_d` output 32: `pc_d + 8`, the link value for jal/jalr.
- `redirect_d` output 1: combinational; high when the D instruction redirects fetch this cycle.
- `fetch_err` output 1: registered with IF/ID; high when the PC captured into D is misaligned or outside IM.

Behaviour:
- **Reset** (sync, highest priority):
  - `pc_f = RESET_PC`.
  - `instr_d = 0` (nop).
  - `pc_d = RESET_PC`.
  - `fetch_err = 0`.
  - Any in-flight branch is discarded.
- **Offset and targets** (all arithmetic is 32-bit, wrapping mod 2^32):
  - `imm16 = instr_d[15:0]`, sign-extended and shifted left by 2.
  - Branch target = `pc_d + 4 + (sext(imm16) << 2)`.
  - j/jal target = `{pc_d[31:28], instr_d[25:0], 2'b00}`.
  - jr target = `rs_val_d`, unmodified. Misalignment is flagged via `fetch_err` after fetch, not corrected.
- **taken**, per `br_op_d`:
  - beq: `equal_in`.
  - bne: `!equal_in`.
  - bgez: `bgez_in`.
  - bgtz: `bgtz_in`.
  - bltz: `bltz_in`.
  - blez: `blez_in`.
  - Otherwise 0.
- **redirect_d** = `!stall && (taken || j_op_d == 1 || j_op_d == 2)`.
- **Next-PC priority:** reset > stall (hold `pc_f`) > jump > taken branch > `pc_f + 4`. If `br_op_d` and `j_op_d` are both nonzero (illegal decode), the jump wins.
- **IF/ID update:**
  - If `!stall`: `instr_d <= instr_f`, `pc_d <= pc_f`.
  - If `stall`: hold.
  - A redirect does NOT flush IF/ID; the delay-slot instruction proceeds.
- **Stall with branch in D:** no redirect. The branch re-evaluates with fresh flags on the first non-stall cycle. The flags may change during the stall and must not be latched.
- **Latency:** the target appears on `pc_f` one cycle after the branch is in D with `stall = 0`.
- **PC wrap:** `0xFFFF_FFFC + 4 = 0`, no special handling.
- **fetch_err:** registered with IF/ID when `pc_f[1:0] != 0` or `pc_f` is outside `[IM_BASE, IM_BASE + 4*IM_WORDS)`.
- **Reset during stall or redirect:** reset wins; no partial state survives.

Optional Feature:
- Macro: `BRANCH_LIKELY_EN`.
- **Defined:** extra input `likely_d` (1 bit) marks beql/bnel-style branches. When `likely_d && br_op_d != 0 && !taken && !stall`:
  - Next cycle, IF/ID loads `instr_d = 0` (annulled delay slot).
  - `pc_d` still loads `pc_f`.
  - `fetch_err` is forced to 0.
  - A one-bit annul flag register records the squash. It clears on any non-stall cycle and on reset.
- **Undefined:** no `likely_d` port, no annul logic; delay slot is always executed.

Decomposition:
- Shared package `mips_pkg` holds:
  - The `br_op` codes (`BR_NONE`, `BR_BEQ`, `BR_BNE`, `BR_BGEZ`, `BR_BGTZ`, `BR_BLTZ`, `BR_BLEZ`).
  - The `j_op` codes (`J_NONE`, `J_IMM`, `J_REG`).
  - The `RESET_PC` and nop constants.
- One natural sub-module: `npc_calc`, purely combinational. It computes taken, the target and `redirect_d`. The PC and IF/ID registers stay in `fetch_npc_unit`.

Test Plan:
- **Reset:** assert `reset` for 2 cycles, then release → `pc_f = 0x3000`, `instr_d = 0`; next cycles `pc_f` = `0x3004`, then `0x3008`.
- **beq taken, forward:** `pc_d = 0x3000`, `instr_d[15:0] = 0x0003`, `br_op_d = 1`, `equal_in = 1`, `pc_f = 0x3004` → `instr_d` = delay slot from `0x3004`, `pc_f = 0x3010`.
- **bltz taken, backward:** `pc_d = 0x3020`, `imm16 = 0xFFFC`, `bltz_in = 1` → `pc_f = 0x3014`. Same stimulus with `bltz_in = 0` → `pc_f = pc_f + 4`.
- **Stall:** branch in D, `stall = 1` for 3 cycles while `equal_in` toggles → `pc_f`/`instr_d`/`pc_d` frozen, `redirect_d = 0`; first non-stall cycle with `equal_in = 1` → redirect taken.
- **Jumps:**
  - jal with `instr_d[25:0] = 0x0000C10`, `pc_d = 0x3008` → `pc_f = 0x0000_3040`, `pc8_d = 0x3010`.
  - jr with `rs_val_d = 0x3002` → `pc_f = 0x3002`; next cycle `fetch_err = 1`.
- **BRANCH_LIKELY_EN:** `likely_d = 1`, bne not taken → `instr_d = 0` next cycle; if taken, the delay slot is preserved.
